// File: rtl/motion_alarm_ctrl.sv
// Motion alarm controller: 2-flop input sync, per-zone PIR debounce, OFF/ARMING/ARMED/ALARM FSM with zone latch.
// Define TRIGGER_COUNT_EN to add saturating per-zone trigger counters on trig_cnt_1..3.
module motion_alarm_ctrl #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int ARM_DELAY       = 4,
  parameter int ALARM_TIMEOUT   = 64,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             turn,
  input  logic             stop_alarm,
  input  logic             pir_sensor_1,
  input  logic             pir_sensor_2,
  input  logic             pir_sensor_3,
  output logic             alarm,
  output logic             armed,
  output logic [2:0]       zone,
  output logic             alarm_event
`ifdef TRIGGER_COUNT_EN
  ,
  output logic [CNT_W-1:0] trig_cnt_1,
  output logic [CNT_W-1:0] trig_cnt_2,
  output logic [CNT_W-1:0] trig_cnt_3
`endif
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 || ARM_DELAY < 1 || ARM_DELAY > 255 ||
      ALARM_TIMEOUT < 1 || ALARM_TIMEOUT > 65535 || CNT_W < 1) begin : g_bad_param
    $error("motion_alarm_ctrl: parameter out of range");
  end

  localparam logic [3:0]  DB_MAX   = 4'(DEBOUNCE_CYCLES);
  localparam logic [15:0] ARM_LAST = 16'(ARM_DELAY - 1);
  localparam logic [15:0] TO_LAST  = 16'(ALARM_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_OFF, ST_ARMING, ST_ARMED, ST_ALARM} state_t;

  logic [4:0] sync_1;
  logic [4:0] sync_2;
  logic       turn_s;
  logic       stop_s;
  logic [2:0] pir_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {pir_sensor_3, pir_sensor_2, pir_sensor_1, stop_alarm, turn};
      sync_2 <= sync_1;
    end
  end

  assign turn_s = sync_2[0];
  assign stop_s = sync_2[1];
  assign pir_s  = sync_2[4:2];

  logic [3:0] db_cnt [3];
  logic [2:0] q;
  logic [2:0] q_d;
  logic [2:0] rise;

  always_comb begin
    q = '0;
    for (int i = 0; i < 3; i++) q[i] = (db_cnt[i] == DB_MAX);
  end

  assign rise = q & ~q_d;

  // Counter saturates at the threshold so a held input keeps q high without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      q_d <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!pir_s[i])
          db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_MAX)
          db_cnt[i] <= db_cnt[i] + 4'd1;
      end
      q_d <= q;
    end
  end

  state_t      state;
  logic [15:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      timer       <= '0;
      zone        <= '0;
      alarm       <= 1'b0;
      armed       <= 1'b0;
      alarm_event <= 1'b0;
    end else begin
      alarm_event <= 1'b0;
      if (!turn_s) begin
        state <= ST_OFF;
        zone  <= '0;
        alarm <= 1'b0;
        armed <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            state <= ST_ARMING;
            timer <= '0;
          end
          ST_ARMING: begin
            if (timer == ARM_LAST) begin
              state <= ST_ARMED;
              armed <= 1'b1;
            end else begin
              timer <= timer + 16'd1;
            end
          end
          ST_ARMED: begin
            if (|rise) begin
              state       <= ST_ALARM;
              alarm       <= 1'b1;
              zone        <= rise;
              timer       <= '0;
              alarm_event <= 1'b1;
            end
          end
          ST_ALARM: begin
            // Late rises accumulate; an acknowledge wipes them, a timeout keeps them visible.
            if (stop_s) begin
              state <= ST_ARMED;
              alarm <= 1'b0;
              zone  <= '0;
            end else if (timer == TO_LAST) begin
              state <= ST_ARMED;
              alarm <= 1'b0;
              zone  <= zone | rise;
            end else begin
              zone  <= zone | rise;
              timer <= timer + 16'd1;
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

`ifdef TRIGGER_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] trig_cnt [3];
  logic             cnt_en;

  assign cnt_en = (state == ST_ARMED) || (state == ST_ALARM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) trig_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_en && rise[i] && trig_cnt[i] != CNT_MAX)
          trig_cnt[i] <= trig_cnt[i] + CNT_ONE;
      end
    end
  end

  assign trig_cnt_1 = trig_cnt[0];
  assign trig_cnt_2 = trig_cnt[1];
  assign trig_cnt_3 = trig_cnt[2];
`endif

endmodule
